// File: rtl/ring_mul_seq_pkg.sv
// Shared constants for the ring-timed sequential multiplier: operand widths,
// one-hot ring phases and the controller state encoding.
package ring_mul_seq_pkg;

   localparam int unsigned OPW = 4;
   localparam int unsigned PW  = 8;

   localparam logic [5:0] T0 = 6'b000001;
   localparam logic [5:0] T1 = 6'b000010;
   localparam logic [5:0] T2 = 6'b000100;
   localparam logic [5:0] T3 = 6'b001000;
   localparam logic [5:0] T4 = 6'b010000;
   localparam logic [5:0] T5 = 6'b100000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   // The phase the ring must present on the cycle after phase p.
   function automatic logic [5:0] next_phase(input logic [5:0] p);
      return {p[4:0], p[5]};
   endfunction

endpackage

// File: rtl/ring_mul_dp.sv
// Shift-add datapath: operand latches, accumulator, shifting multiplicand and
// multiplier, and the product register written on the final phase.
module ring_mul_dp
   import ring_mul_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rstb,
   input  logic          load,
   input  logic          step_en,
   input  logic [5:0]    phase,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [PW-1:0] product
);

   logic [OPW-1:0] a_lat, b_lat;
   logic [OPW-1:0] mplier;
   logic [PW-1:0]  mcand;
   logic [PW-1:0]  acc;
   logic [PW-1:0]  acc_step;

   always_comb begin
      acc_step = acc;
      if (mplier[0]) acc_step = acc + mcand;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_lat   <= '0;
         b_lat   <= '0;
         mplier  <= '0;
         mcand   <= '0;
         acc     <= '0;
         product <= '0;
      end else begin
         if (load) begin
            a_lat <= a;
            b_lat <= b;
         end
         if (step_en) begin
            case (phase)
               T0: begin
                  acc    <= '0;
                  mcand  <= {{(PW-OPW){1'b0}}, a_lat};
                  mplier <= b_lat;
               end
               T1, T2, T3, T4: begin
                  acc    <= acc_step;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               T5: product <= acc_step;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/ring_mul_seq.sv
// Sequential 4x4 multiplier paced by an external six-phase one-hot ring;
// the controller checks the ring phase every RUN cycle and faults on error.
module ring_mul_seq
   import ring_mul_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rstb,
   input  logic          start,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   input  logic [5:0]    timing,
   output logic          cnt_en,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] product,
   output logic          err
);

   state_t     state, state_nx;
   logic [5:0] exp_phase;
   logic       phase_ok;
   logic       load;
   logic       step_en;

   // Matching the expected phase exactly covers both the one-hot and successor checks.
   assign phase_ok = (timing == exp_phase);
   assign load     = (state == IDLE) && start && (timing == T0);
   assign step_en  = (state == RUN) && phase_ok;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)            exp_phase <= T0;
      else if (step_en)     exp_phase <= next_phase(exp_phase);
      else if (state != RUN) exp_phase <= T0;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = (timing == T0) ? RUN : FAULT;
         RUN: begin
            if (!phase_ok)        state_nx = FAULT;
            else if (timing == T5) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         FAULT:   state_nx = FAULT;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cnt_en = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      case (state)
         RUN: begin
            cnt_en = 1'b1;
            busy   = 1'b1;
         end
         DONE:  done = 1'b1;
         FAULT: err  = 1'b1;
         default: ;
      endcase
   end

   ring_mul_dp u_dp (
      .clk     (clk),
      .rstb    (rstb),
      .load    (load),
      .step_en (step_en),
      .phase   (timing),
      .a       (a),
      .b       (b),
      .product (product)
   );

endmodule

// File: tb/tb_ring_mul_seq.sv
// Directed bench: ring_mul_seq driven by a six-phase one-hot ring whose
// advance enable is the DUT's cnt_en, with an override to inject phase faults.
module tb_ring_mul_seq;

   logic       clk;
   logic       rstb;
   logic       start;
   logic [3:0] a, b;
   logic [5:0] timing;
   logic       cnt_en, busy, done, err;
   logic [7:0] product;

   logic [5:0] ring;
   logic       force_en;
   logic [5:0] force_val;

   int tests  = 0;
   int failed = 0;
   int en_cnt, done_cnt, done_at;
   logic [7:0] last_prod;
   logic [7:0] mid_prod;

   ring_mul_seq dut (
      .clk     (clk),
      .rstb    (rstb),
      .start   (start),
      .a       (a),
      .b       (b),
      .timing  (timing),
      .cnt_en  (cnt_en),
      .busy    (busy),
      .done    (done),
      .product (product),
      .err     (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Six-phase ring: resets to T0 on rstb, rotates while cnt_en is high.
   always @(posedge clk or negedge rstb) begin
      if (!rstb)       ring <= 6'b000001;
      else if (cnt_en) ring <= {ring[4:0], ring[5]};
   end

   assign timing = force_en ? force_val : ring;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input bit hold,
                         input bit toggle, input int ncyc, input logic [7:0] exp,
                         input string tag);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      en_cnt = 0; done_cnt = 0; done_at = 0; mid_prod = 8'hxx;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (cnt_en) en_cnt++;
         if (done) begin
            done_cnt++;
            done_at = i;
         end
         if (i == 3) mid_prod = product;
         if (toggle && i == 3) begin
            a = ~av;
            b = ~bv;
         end
         if (!hold || i >= 7) start = 1'b0;
      end
      chk({tag, "_cnt_en_cycles"}, en_cnt, 6);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_done_cycle"}, done_at, 7);
      chk({tag, "_product_held_in_run"}, int'(mid_prod), int'(last_prod));
      chk({tag, "_product"}, int'(product), int'(exp));
      chk({tag, "_err"}, int'(err), 0);
      last_prod = exp;
   endtask

   initial begin
      rstb = 1'b1; start = 1'b0; a = '0; b = '0;
      force_en = 1'b0; force_val = '0;
      last_prod = 8'h00;
      #2 rstb = 1'b0;
      #1;
      chk("reset_cnt_en", int'(cnt_en), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_product", int'(product), 0);
      @(negedge clk);
      @(negedge clk);
      rstb = 1'b1;

      run_op(4'd9, 4'd13, 1'b0, 1'b0, 8, 8'd117, "mul_9x13");

      // Back-to-back: the second start lands on the first IDLE cycle.
      run_op(4'd15, 4'd15, 1'b0, 1'b0, 7, 8'd225, "mul_15x15");
      run_op(4'd0, 4'd7, 1'b0, 1'b0, 8, 8'd0, "mul_0x7");

      run_op(4'd3, 4'd5, 1'b1, 1'b1, 12, 8'd15, "hold_toggle_3x5");
      run_op(4'd11, 4'd12, 1'b0, 1'b0, 8, 8'd132, "mul_11x12");

      // Phase fault injected during T2.
      @(negedge clk);
      a = 4'd5; b = 4'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("fault_pre_busy", int'(busy), 1);
      force_en = 1'b1; force_val = 6'b000011;
      @(negedge clk);
      chk("fault_err", int'(err), 1);
      chk("fault_cnt_en", int'(cnt_en), 0);
      chk("fault_busy", int'(busy), 0);
      chk("fault_product", int'(product), int'(last_prod));
      force_en = 1'b0;
      start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      chk("fault_sticky_err", int'(err), 1);
      chk("fault_sticky_cnt_en", int'(cnt_en), 0);
      chk("fault_sticky_done", int'(done), 0);
      chk("fault_sticky_product", int'(product), int'(last_prod));
      rstb = 1'b0;
      #1;
      chk("fault_reset_err", int'(err), 0);
      chk("fault_reset_product", int'(product), 0);
      last_prod = 8'h00;
      @(negedge clk);
      rstb = 1'b1;

      run_op(4'd2, 4'd8, 1'b0, 1'b0, 8, 8'd16, "mul_2x8");

      // Reset pulse while the ring sits at T3.
      @(negedge clk);
      a = 4'd12; b = 4'd11; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("midrun_busy", int'(busy), 1);
      rstb = 1'b0;
      #1;
      chk("midrun_reset_busy", int'(busy), 0);
      chk("midrun_reset_cnt_en", int'(cnt_en), 0);
      chk("midrun_reset_done", int'(done), 0);
      chk("midrun_reset_err", int'(err), 0);
      chk("midrun_reset_product", int'(product), 0);
      last_prod = 8'h00;
      @(negedge clk);
      rstb = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("midrun_no_done", done_cnt, 0);

      run_op(4'd6, 4'd7, 1'b0, 1'b0, 8, 8'd42, "mul_6x7");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/ring_mul_seq.md
RING_MUL_SEQ -- requirements
Module: ring_mul_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, shared with the six-phase timing ring.
REQ-002 SHALL have port: rstb  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  request one multiply; sampled only in IDLE.
REQ-004 SHALL have port: a  input  4  multiplicand, unsigned.
REQ-005 SHALL have port: b  input  4  multiplier, unsigned.
REQ-006 SHALL have port: timing  input  6  one-hot phase word from the ring (bit0 = T0 … bit5 = T5).
REQ-007 SHALL have port: cnt_en  output  1  advance enable driven to the ring's cnt_en.
REQ-008 SHALL have port: busy  output  1  high in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: product  output  8  a*b, held until next completion.
REQ-011 SHALL have port: err  output  1  sticky phase-fault flag.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE, FAULT, held in a state register; cnt_en, busy, done decoded from state only (cnt_en = busy = RUN; done = DONE).
REQ-013 IDLE: start=1 and timing=6'b000001 SHALL latch a, b and go RUN next edge; start=1 with any other timing SHALL set err and go FAULT.
REQ-014 RUN SHALL act on the phase present each cycle: T0 clear acc, load mcand={4'b0,a_lat}, mplier=b_lat; T1..T4 one shift-add step each; T5 load product<=acc-with-final-step-result, go DONE.
REQ-015 Shift-add step: if mplier[0] acc<=acc+mcand (8-bit, no overflow possible); mcand<<=1; mplier>>=1.
REQ-016 Latency: start sampled at edge k -> RUN cycles k+1..k+6 (T0..T5) -> done high during cycle k+7 -> IDLE at k+8; ring wraps to T0 on the T5 edge.
REQ-017 DONE SHALL last exactly one cycle and return to IDLE unconditionally; start during DONE SHALL be ignored.
REQ-018 start while RUN or DONE SHALL be ignored; a, b changes during RUN SHALL not affect the result.
REQ-019 During RUN, timing not exactly one-hot, or not the successor of the previous phase, SHALL set err and go FAULT on that edge.
REQ-020 FAULT SHALL hold cnt_en=0, busy=0, done=0, err=1, product unchanged; exited only by reset.
REQ-021 product SHALL hold its last value through IDLE, RUN and FAULT; updated only on the T5 edge.

Reset
REQ-022 rstb=0 SHALL immediately force state=IDLE, cnt_en=0, busy=0, done=0, err=0, product=8'h00, acc/mcand/mplier/latches=0.
REQ-023 Reset mid-RUN SHALL abort without done; first start after release SHALL behave per REQ-013 (ring resets to T0 on same rstb).

Structure
REQ-024 Shared package SHALL hold phase constants T0..T5 (6-bit one-hot), state encoding, widths (OPW=4, PW=8).
REQ-025 Datapath (acc, mcand, mplier, step logic) SHALL be one sub-module ring_mul_dp; FSM and phase checking stay in ring_mul_seq.

Verification
REQ-026 Bench SHALL instantiate the real six-phase ring with ring_mul_seq (cnt_en looped back) and cover:
REQ-027 a=9, b=13, start 1 cycle -> cnt_en high 6 cycles, done pulse at k+7, product=8'd117, err=0.
REQ-028 a=15, b=15 then a=0, b=7 back-to-back -> product=8'd225 then 8'd0, each with exactly one done pulse.
REQ-029 start held high through RUN, a/b toggled mid-run -> single operation, product from values latched at start.
REQ-030 timing forced to 6'b000011 during T2 -> err=1, cnt_en=0 next cycle, product unchanged; persists until rstb=0.
REQ-031 rstb pulsed low at T3 -> all outputs 0 asynchronously, no done; subsequent a=6, b=7 -> product=8'd42.
